// File: rtl/m_final_cpa_pkg.sv
// Shared multiplier constants and the two-row bundle passed between the
// reduction stages and the final carry-propagate adder.
package m_final_cpa_pkg;

    localparam int PRODUCT_W = 16;
    localparam int OPERAND_W = 8;

    typedef struct packed {
        logic [PRODUCT_W-1:0] row_s;
        logic [PRODUCT_W-1:0] row_c;
    } rows_t;

endpackage

// File: rtl/m_final_cpa_cpa_slice.sv
// N-bit ripple adder slice with carry in and carry out; the final adder is
// built from two of these separated by a pipeline register.
module cpa_slice
    import m_final_cpa_pkg::*;
#(
    parameter int N = OPERAND_W
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/m_final_cpa.sv
// Two-stage pipelined carry-propagate adder closing the 8x8 multiplier:
// low slice in stage 1, high slice plus the registered low carry in stage 2.
module m_final_cpa
    import m_final_cpa_pkg::*;
#(
    parameter int WIDTH = PRODUCT_W,
    parameter int SPLIT = OPERAND_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] row_s,
    input  logic [WIDTH-1:0] row_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             overflow
);

    localparam int HI_W = WIDTH - SPLIT;

    logic              s1_valid_r;
    logic [SPLIT-1:0]  lo_sum_r;
    logic              lo_cout_r;
    logic [HI_W-1:0]   hi_s_r;
    logic [HI_W-1:0]   hi_c_r;

    logic              adv1_s;
    logic              adv2_s;
    logic [SPLIT-1:0]  lo_sum_s;
    logic              lo_cout_s;
    logic [HI_W-1:0]   hi_sum_s;
    logic              hi_cout_s;

    // A stage may advance when its downstream neighbour is empty or draining.
    assign adv2_s   = !out_valid || out_ready;
    assign adv1_s   = !s1_valid_r || adv2_s;
    assign in_ready = adv1_s;

    cpa_slice #(.N(SPLIT)) u_lo (
        .a    (row_s[SPLIT-1:0]),
        .b    (row_c[SPLIT-1:0]),
        .cin  (1'b0),
        .sum  (lo_sum_s),
        .cout (lo_cout_s)
    );

    cpa_slice #(.N(HI_W)) u_hi (
        .a    (hi_s_r),
        .b    (hi_c_r),
        .cin  (lo_cout_r),
        .sum  (hi_sum_s),
        .cout (hi_cout_s)
    );

    // Stage 1: low partial sum and the untouched upper operand slices.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            lo_sum_r   <= {SPLIT{1'b0}};
            lo_cout_r  <= 1'b0;
            hi_s_r     <= {HI_W{1'b0}};
            hi_c_r     <= {HI_W{1'b0}};
        end else if (adv1_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                lo_sum_r  <= lo_sum_s;
                lo_cout_r <= lo_cout_s;
                hi_s_r    <= row_s[WIDTH-1:SPLIT];
                hi_c_r    <= row_c[WIDTH-1:SPLIT];
            end
        end
    end

    // Stage 2: finished product; data only moves when stage 1 holds an item.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            product   <= {WIDTH{1'b0}};
            overflow  <= 1'b0;
        end else if (adv2_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                product  <= {hi_sum_s, lo_sum_r};
                overflow <= hi_cout_s;
            end
        end
    end

endmodule
